// File: rtl/sram_dp_param_if.sv
// Port bundle for the dual-port SRAM model: two request/response ports plus collision flag.
interface sram_dp_param_if #(
    parameter int unsigned WIDTH  = 18,
    parameter int unsigned ADDR_W = 10
);
    logic              cen_a;
    logic              cen_b;
    logic              wen_a;
    logic              wen_b;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [WIDTH-1:0]  wmsk_a;
    logic [WIDTH-1:0]  wmsk_b;
    logic [WIDTH-1:0]  wdata_a;
    logic [WIDTH-1:0]  wdata_b;
    logic [WIDTH-1:0]  rdata_a;
    logic [WIDTH-1:0]  rdata_b;
    logic              rvalid_a;
    logic              rvalid_b;
    logic              collision;

    modport master (
        output cen_a, cen_b, wen_a, wen_b, addr_a, addr_b,
        output wmsk_a, wmsk_b, wdata_a, wdata_b,
        input  rdata_a, rdata_b, rvalid_a, rvalid_b, collision
    );

    modport slave (
        input  cen_a, cen_b, wen_a, wen_b, addr_a, addr_b,
        input  wmsk_a, wmsk_b, wdata_a, wdata_b,
        output rdata_a, rdata_b, rvalid_a, rvalid_b, collision
    );
endinterface

// File: rtl/sram_dp_param.sv
// Parametrised true dual-port synchronous SRAM with bit-masked writes, selectable
// read-during-write behaviour, optional output register and cross-port collision flag.
module sram_dp_param #(
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned WIDTH    = 18,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned RDW_MODE = 1,
    parameter int unsigned OUT_REG  = 0,
    parameter logic [WIDTH*DEPTH-1:0] INIT = '0
) (
    input logic           clk,
    input logic           rst_n,
    sram_dp_param_if.slave bus
);
    localparam int unsigned IdxW = $clog2(WIDTH * DEPTH);

    // Flat storage so the contents can be preloaded from INIT without an initial block.
    logic [WIDTH*DEPTH-1:0] mem = INIT;

    logic              acc_a, acc_b, in_a, in_b, wr_a, wr_b, same, coll;
    logic [ADDR_W-1:0] idx_a, idx_b;
    logic [IdxW-1:0]   base_a, base_b;
    logic [WIDTH-1:0]  old_a, old_b, new_a, new_b, fin_a, fin_b;
    logic [WIDTH-1:0]  rd_a, rd_b;
    logic              rv_a, rv_b;

    logic [WIDTH-1:0]  rdata1_a, rdata1_b;
    logic              rvalid1_a, rvalid1_b, coll1;

    // Decode both requests, merge write data and resolve same-address dual writes.
    always_comb begin
        acc_a  = ~bus.cen_a;
        acc_b  = ~bus.cen_b;
        in_a   = 32'(bus.addr_a) < DEPTH;
        in_b   = 32'(bus.addr_b) < DEPTH;
        wr_a   = acc_a & ~bus.wen_a & in_a;
        wr_b   = acc_b & ~bus.wen_b & in_b;
        same   = bus.addr_a == bus.addr_b;
        // Out-of-range addresses are clamped to word 0 only to keep the select in bounds.
        idx_a  = in_a ? bus.addr_a : '0;
        idx_b  = in_b ? bus.addr_b : '0;
        base_a = IdxW'(32'(idx_a) * WIDTH);
        base_b = IdxW'(32'(idx_b) * WIDTH);
        old_a  = in_a ? mem[base_a +: WIDTH] : '0;
        old_b  = in_b ? mem[base_b +: WIDTH] : '0;
        new_b  = (old_b & bus.wmsk_b) | (bus.wdata_b & ~bus.wmsk_b);
        // A is merged on top of B's result so A's unmasked bits take priority.
        new_a  = (((wr_b && same) ? new_b : old_a) & bus.wmsk_a) | (bus.wdata_a & ~bus.wmsk_a);
        fin_a  = new_a;
        fin_b  = (wr_a && same) ? new_a : new_b;
        coll   = acc_a & acc_b & in_a & in_b & same & (~bus.wen_a | ~bus.wen_b);
    end

    // Per-port response for this edge; no-change writes keep the previous rdata.
    always_comb begin
        rv_a = 1'b0;
        rd_a = rdata1_a;
        if (acc_a) begin
            if (bus.wen_a || RDW_MODE == 0) begin
                rv_a = 1'b1;
                rd_a = old_a;
            end else if (RDW_MODE == 1) begin
                rv_a = 1'b1;
                rd_a = wr_a ? fin_a : '0;
            end
        end
        rv_b = 1'b0;
        rd_b = rdata1_b;
        if (acc_b) begin
            if (bus.wen_b || RDW_MODE == 0) begin
                rv_b = 1'b1;
                rd_b = old_b;
            end else if (RDW_MODE == 1) begin
                rv_b = 1'b1;
                rd_b = wr_b ? fin_b : '0;
            end
        end
    end

    // Array update; reset blocks writes but never clears contents.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (wr_b) mem[base_b +: WIDTH] <= fin_b;
            if (wr_a) mem[base_a +: WIDTH] <= fin_a;
        end
    end

    // First output stage: read data, valid pulses and collision flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata1_a  <= '0;
            rdata1_b  <= '0;
            rvalid1_a <= 1'b0;
            rvalid1_b <= 1'b0;
            coll1     <= 1'b0;
        end else begin
            rdata1_a  <= rd_a;
            rdata1_b  <= rd_b;
            rvalid1_a <= rv_a;
            rvalid1_b <= rv_b;
            coll1     <= coll;
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [WIDTH-1:0] rdata2_a, rdata2_b;
        logic             rvalid2_a, rvalid2_b, coll2;

        // Optional output pipeline stage, collision delayed to stay aligned with rvalid.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata2_a  <= '0;
                rdata2_b  <= '0;
                rvalid2_a <= 1'b0;
                rvalid2_b <= 1'b0;
                coll2     <= 1'b0;
            end else begin
                rdata2_a  <= rdata1_a;
                rdata2_b  <= rdata1_b;
                rvalid2_a <= rvalid1_a;
                rvalid2_b <= rvalid1_b;
                coll2     <= coll1;
            end
        end

        assign bus.rdata_a   = rdata2_a;
        assign bus.rdata_b   = rdata2_b;
        assign bus.rvalid_a  = rvalid2_a;
        assign bus.rvalid_b  = rvalid2_b;
        assign bus.collision = coll2;
    end else begin : g_direct
        assign bus.rdata_a   = rdata1_a;
        assign bus.rdata_b   = rdata1_b;
        assign bus.rvalid_a  = rvalid1_a;
        assign bus.rvalid_b  = rvalid1_b;
        assign bus.collision = coll1;
    end
endmodule

// File: tb/tb_sram_dp_param.sv
// Bench for sram_dp_param: four configurations share one directed stimulus stream and are
// checked every cycle against a word-level model, plus literal spot checks.
module tb_sram_dp_param;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen_a, cen_b, wen_a, wen_b;
    logic [9:0] addr_a, addr_b;
    logic [17:0] wmsk_a, wmsk_b, wdata_a, wdata_b;

    logic [17:0] o_rd [4][2];
    logic        o_v  [4][2];
    logic        o_c  [4];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    // Configs: 0 read-first, 1 write-first, 2 no-change, 3 DEPTH=1000 write-first registered.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned Dp = (g == 3) ? 1000 : 1024;
        localparam int unsigned Md = (g == 3) ? 1 : g;
        localparam int unsigned Or = (g == 3) ? 1 : 0;
        localparam logic [18*Dp-1:0] Init = (18*Dp)'(18'h01234);

        sram_dp_param_if #(.WIDTH(18), .ADDR_W(10)) bus ();

        assign bus.cen_a   = cen_a;
        assign bus.cen_b   = cen_b;
        assign bus.wen_a   = wen_a;
        assign bus.wen_b   = wen_b;
        assign bus.addr_a  = addr_a;
        assign bus.addr_b  = addr_b;
        assign bus.wmsk_a  = wmsk_a;
        assign bus.wmsk_b  = wmsk_b;
        assign bus.wdata_a = wdata_a;
        assign bus.wdata_b = wdata_b;
        assign o_rd[g][0]  = bus.rdata_a;
        assign o_rd[g][1]  = bus.rdata_b;
        assign o_v[g][0]   = bus.rvalid_a;
        assign o_v[g][1]   = bus.rvalid_b;
        assign o_c[g]      = bus.collision;

        sram_dp_param #(
            .DEPTH(Dp), .WIDTH(18), .ADDR_W(10), .RDW_MODE(Md), .OUT_REG(Or), .INIT(Init)
        ) dut (
            .clk(clk),
            .rst_n(rst_n),
            .bus(bus)
        );
    end

    function automatic void chk(input string nm, input logic [17:0] act, input logic [17:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    // ---------------- behavioural model ----------------
    logic [17:0] mm [4][1024];
    int unsigned dep  [4] = '{1024, 1024, 1024, 1000};
    int unsigned mode [4] = '{0, 1, 2, 1};
    bit          oreg [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [17:0] s1_rd [4][2];
    logic [17:0] s2_rd [4][2];
    logic        s1_v  [4][2];
    logic        s2_v  [4][2];
    logic        s1_c  [4];
    logic        s2_c  [4];

    // Word stored at address x after this edge: per bit A's unmasked bit, else B's, else old.
    function automatic logic [17:0] merged(input int d, input logic [9:0] x,
                                           input logic wra, input logic wrb);
        logic [17:0] w;
        w = mm[d][x];
        for (int i = 0; i < 18; i++) begin
            if (wra && addr_a == x && !wmsk_a[i]) w[i] = wdata_a[i];
            else if (wrb && addr_b == x && !wmsk_b[i]) w[i] = wdata_b[i];
        end
        return w;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 4; d++) begin
            for (int p = 0; p < 2; p++) begin
                s1_rd[d][p] = '0; s2_rd[d][p] = '0; s1_v[d][p] = 1'b0; s2_v[d][p] = 1'b0;
            end
            s1_c[d] = 1'b0; s2_c[d] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 4; d++) begin
            logic        c [2];
            logic        w [2];
            logic [9:0]  ad [2];
            logic        inr [2];
            logic        wr [2];
            logic [17:0] old [2];
            logic [17:0] f [2];
            logic [17:0] nrd [2];
            logic        nv [2];
            logic        col;
            c[0] = cen_a; c[1] = cen_b; w[0] = wen_a; w[1] = wen_b;
            ad[0] = addr_a; ad[1] = addr_b;
            for (int p = 0; p < 2; p++) begin
                inr[p] = 32'(ad[p]) < dep[d];
                wr[p]  = !c[p] && !w[p] && inr[p];
                old[p] = inr[p] ? mm[d][ad[p]] : 18'h0;
            end
            for (int p = 0; p < 2; p++) f[p] = wr[p] ? merged(d, ad[p], wr[0], wr[1]) : 18'h0;
            for (int p = 0; p < 2; p++) if (wr[p]) mm[d][ad[p]] = f[p];
            for (int p = 0; p < 2; p++) begin
                nrd[p] = s1_rd[d][p];
                nv[p]  = 1'b0;
                if (!c[p]) begin
                    if (w[p] || mode[d] == 0) begin nrd[p] = old[p]; nv[p] = 1'b1; end
                    else if (mode[d] == 1)    begin nrd[p] = f[p];   nv[p] = 1'b1; end
                end
            end
            col = !c[0] && !c[1] && inr[0] && inr[1] && ad[0] == ad[1] && (!w[0] || !w[1]);
            for (int p = 0; p < 2; p++) begin
                s2_rd[d][p] = s1_rd[d][p]; s2_v[d][p] = s1_v[d][p];
                s1_rd[d][p] = nrd[p];      s1_v[d][p] = nv[p];
            end
            s2_c[d] = s1_c[d];
            s1_c[d] = col;
        end
    endtask

    initial begin
        for (int d = 0; d < 4; d++)
            for (int i = 0; i < 1024; i++) mm[d][i] = (i == 0) ? 18'h01234 : 18'h0;
        model_clear();
    end

    // Single compare process: advance model on the edge, check all outputs mid-cycle.
    initial begin
        forever begin
            @(posedge clk);
            if (rst_n) model_step();
            else model_clear();
            @(negedge clk);
            #1;
            if (!rst_n) model_clear();
            for (int d = 0; d < 4; d++) begin
                for (int p = 0; p < 2; p++) begin
                    chk($sformatf("d%0d rdata_%s", d, p ? "b" : "a"), o_rd[d][p],
                        oreg[d] ? s2_rd[d][p] : s1_rd[d][p]);
                    chk($sformatf("d%0d rvalid_%s", d, p ? "b" : "a"), 18'(o_v[d][p]),
                        18'(oreg[d] ? s2_v[d][p] : s1_v[d][p]));
                end
                chk($sformatf("d%0d collision", d), 18'(o_c[d]), 18'(oreg[d] ? s2_c[d] : s1_c[d]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic pa(input logic c, input logic w, input logic [9:0] a,
                      input logic [17:0] m, input logic [17:0] dt);
        cen_a = c; wen_a = w; addr_a = a; wmsk_a = m; wdata_a = dt;
    endtask

    task automatic pb(input logic c, input logic w, input logic [9:0] a,
                      input logic [17:0] m, input logic [17:0] dt);
        cen_b = c; wen_b = w; addr_b = a; wmsk_b = m; wdata_b = dt;
    endtask

    // One request edge; returns mid-cycle with both ports idle again.
    task automatic tick();
        @(negedge clk);
        pa(1'b1, 1'b1, 10'd0, 18'h0, 18'h0);
        pb(1'b1, 1'b1, 10'd0, 18'h0, 18'h0);
    endtask

    initial begin
        pa(1'b1, 1'b1, 10'd0, 18'h0, 18'h0);
        pb(1'b1, 1'b1, 10'd0, 18'h0, 18'h0);
        repeat (3) @(negedge clk);
        chk("reset rdata_a", o_rd[0][0], 18'h0);
        chk("reset rvalid_a", 18'(o_v[0][0]), 18'h0);
        chk("reset collision", 18'(o_c[3]), 18'h0);
        rst_n = 1'b1;
        tick();

        // Basic write then read.
        pa(1'b0, 1'b0, 10'd5, 18'h0, 18'h2A5A5); tick();
        chk("rf write old data", o_rd[0][0], 18'h0);
        pa(1'b0, 1'b1, 10'd5, 18'h0, 18'h0); tick();
        chk("basic read", o_rd[0][0], 18'h2A5A5);
        chk("basic rvalid", 18'(o_v[0][0]), 18'h1);

        // Masked write.
        pa(1'b0, 1'b0, 10'd7, 18'h0, 18'h3FFFF); tick();
        pa(1'b0, 1'b0, 10'd7, 18'h0FF00, 18'h0); tick();
        pa(1'b0, 1'b1, 10'd7, 18'h0, 18'h0); tick();
        chk("masked read", o_rd[0][0], 18'h0FF00);

        // Read-during-write modes.
        pa(1'b0, 1'b0, 10'd3, 18'h0, 18'h11111); tick();
        pa(1'b0, 1'b0, 10'd3, 18'h0, 18'h22222); tick();
        chk("rdw0 data", o_rd[0][0], 18'h11111);
        chk("rdw0 valid", 18'(o_v[0][0]), 18'h1);
        chk("rdw1 data", o_rd[1][0], 18'h22222);
        chk("rdw1 valid", 18'(o_v[1][0]), 18'h1);
        chk("rdw2 hold", o_rd[2][0], 18'h0FF00);
        chk("rdw2 valid", 18'(o_v[2][0]), 18'h0);

        // Dual write collision.
        pa(1'b0, 1'b0, 10'd9, 18'h3F000, 18'h00FFF);
        pb(1'b0, 1'b0, 10'd9, 18'h0, 18'h3F000); tick();
        chk("dual write collision", 18'(o_c[0]), 18'h1);
        tick();
        chk("collision one cycle", 18'(o_c[0]), 18'h0);
        pa(1'b0, 1'b1, 10'd9, 18'h0, 18'h0); tick();
        chk("dual write word", o_rd[0][0], 18'h3FFFF);

        // Cross-port read during write.
        pa(1'b0, 1'b1, 10'd9, 18'h0, 18'h0);
        pb(1'b0, 1'b0, 10'd9, 18'h0, 18'h0); tick();
        chk("xport reader old", o_rd[1][0], 18'h3FFFF);
        chk("xport collision", 18'(o_c[1]), 18'h1);
        pa(1'b0, 1'b1, 10'd9, 18'h0, 18'h0); tick();
        chk("xport new word", o_rd[0][0], 18'h0);

        // Dual read, no collision.
        pa(1'b0, 1'b1, 10'd5, 18'h0, 18'h0);
        pb(1'b0, 1'b1, 10'd5, 18'h0, 18'h0); tick();
        chk("dual read b", o_rd[0][1], 18'h2A5A5);
        chk("dual read collision", 18'(o_c[0]), 18'h0);

        // Out of range on the DEPTH=1000 registered instance.
        pa(1'b0, 1'b1, 10'd5, 18'h0, 18'h0); tick();
        pa(1'b0, 1'b1, 10'd1003, 18'h0, 18'h0); tick();
        chk("oreg read 5", o_rd[3][0], 18'h2A5A5);
        pa(1'b0, 1'b0, 10'd1003, 18'h0, 18'h3FFFF);
        pb(1'b0, 1'b0, 10'd1003, 18'h0, 18'h15555); tick();
        chk("oob read data", o_rd[3][0], 18'h0);
        chk("oob read valid", 18'(o_v[3][0]), 18'h1);
        chk("in-range dual write coll", 18'(o_c[0]), 18'h1);
        pa(1'b0, 1'b1, 10'd1003, 18'h0, 18'h0);
        pb(1'b0, 1'b1, 10'd999, 18'h0, 18'h0); tick();
        chk("oob no collision", 18'(o_c[3]), 18'h0);
        tick();
        chk("oob write dropped", o_rd[3][0], 18'h0);
        chk("d0 word 1003 written", o_rd[0][0], 18'h3FFFF);

        // Back-to-back pipelined reads.
        for (int i = 0; i < 4; i++) begin
            pa(1'b0, 1'b1, 10'(i), 18'h0, 18'h0); tick();
            if (i == 1) chk("pipelined word0", o_rd[3][0], 18'h01234);
        end
        tick();
        chk("pipelined word3", o_rd[3][0], 18'h22222);
        tick();

        // Reset between request and registered output.
        pa(1'b0, 1'b1, 10'd5, 18'h0, 18'h0); tick();
        rst_n = 1'b0;
        #2;
        chk("mid reset rdata d0", o_rd[0][0], 18'h0);
        chk("mid reset rvalid d0", 18'(o_v[0][0]), 18'h0);
        chk("mid reset rdata d3", o_rd[3][0], 18'h0);
        chk("mid reset rvalid d3", 18'(o_v[3][0]), 18'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("no late rvalid", 18'(o_v[3][0]), 18'h0);
        tick();
        pa(1'b0, 1'b1, 10'd0, 18'h0, 18'h0); tick();
        chk("init intact", o_rd[0][0], 18'h01234);
        tick();
        chk("init intact oreg", o_rd[3][0], 18'h01234);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
